// File: rtl/mips_pkg.sv
// +--------------------------------------------------------------------------+
// | mips_pkg : shared types and constants for the instruction fetch stage     |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT   = 3'd1,
    HOLD   = 3'd2,
    DROP   = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------------+
// | fetch_stage : instruction fetch FSM with freeze hold buffer, redirect,    |
// |               halt; optional FETCH_STATS_EN adds fetch/stall counters     |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cache_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halted_wire,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ready,
  input  logic [31:0] inst_data,
  output logic [31:0] inst_out,
  output logic [31:0] PC_plus_4,
  output logic        if_valid,
`ifdef FETCH_STATS_EN
  output logic        halted_out,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`else
  output logic        halted_out
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_plus4;
  logic [31:0]  hold_buf, deliver_word;
  logic         deliver, capture, bubble, halt_go;
  logic         active, redirect, halt_req;

  assign pc_plus4  = pc + 32'd4;
  assign inst_req  = (state == FETCH) || (state == WAIT);
  assign inst_addr = pc;

  // Halt and redirect are only honoured while the pipeline is not frozen.
  assign active   = (state != HALTED);
  assign halt_req = active && !cache_done && halted_wire;
  assign redirect = active && !cache_done && branch_taken;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    deliver      = 1'b0;
    deliver_word = hold_buf;
    capture      = 1'b0;
    bubble       = 1'b0;
    halt_go      = 1'b0;
    if (halt_req) begin
      halt_go   = 1'b1;
      state_nxt = HALTED;
    end else if (redirect) begin
      pc_nxt = align_word(branch_target);
      bubble = 1'b1;
      // A request still waiting on memory leaves a stale response to swallow.
      if (state != HOLD && !inst_ready) state_nxt = DROP;
      else                              state_nxt = FETCH;
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (inst_ready) begin
            if (cache_done) begin
              capture   = 1'b1;
              state_nxt = HOLD;
            end else begin
              deliver      = 1'b1;
              deliver_word = inst_data;
              pc_nxt       = pc_plus4;
              state_nxt    = FETCH;
            end
          end else begin
            state_nxt = WAIT;
            bubble    = !cache_done;
          end
        end
        HOLD: begin
          if (!cache_done) begin
            deliver   = 1'b1;
            pc_nxt    = pc_plus4;
            state_nxt = FETCH;
          end
        end
        DROP: begin
          if (inst_ready) state_nxt = FETCH;
          bubble = !cache_done;
        end
        HALTED:  state_nxt = HALTED;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_buf   <= '0;
      inst_out   <= NOP_INST;
      PC_plus_4  <= '0;
      if_valid   <= 1'b0;
      halted_out <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) hold_buf <= inst_data;
      if (halt_go) begin
        if_valid   <= 1'b0;
        halted_out <= 1'b1;
      end else if (deliver) begin
        inst_out  <= deliver_word;
        PC_plus_4 <= pc_plus4;
        if_valid  <= 1'b1;
      end else if (bubble) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic stall_cycle;
  assign stall_cycle = (inst_req && !inst_ready) || (state == HOLD);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (deliver && !halt_go && fetch_count != 32'hFFFF_FFFF)
        fetch_count <= fetch_count + 32'd1;
      if (stall_cycle && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_b  input  1  asynchronous, active-low reset.
REQ-004 cache_done  input  1  pipeline freeze (1 = data cache busy); decode-side outputs SHALL hold while 1.
REQ-005 branch_taken  input  1  single-cycle redirect request from execute.
REQ-006 branch_target  input  32  redirect address.
REQ-007 halted_wire  input  1  halt instruction decoded.
REQ-008 inst_req  output  1  instruction memory request.
REQ-009 inst_addr  output  32  fetch address (equals pc).
REQ-010 inst_ready  input  1  instruction memory response valid; 0..N cycles after inst_req.
REQ-011 inst_data  input  32  fetched word, valid with inst_ready.
REQ-012 inst_out  output  32  instruction to decode register.
REQ-013 PC_plus_4  output  32  address of inst_out plus 4.
REQ-014 if_valid  output  1  inst_out/PC_plus_4 hold a real instruction.
REQ-015 halted_out  output  1  sticky halt indication.
REQ-016 fetch_count, stall_count  output  32 each  statistics (FETCH_STATS_EN only).

Function
REQ-017 States SHALL be FETCH, WAIT, HOLD, DROP, HALTED.
REQ-018 inst_req SHALL be 1 in FETCH and WAIT only; 0 in HOLD, DROP, HALTED.
REQ-019 FETCH SHALL go to WAIT when inst_ready=0 and SHALL accept the response in the same cycle when inst_ready=1.
REQ-020 On accept with cache_done=0: inst_out<=inst_data, PC_plus_4<=pc+4, if_valid<=1, pc<=pc+4, next state FETCH (one instruction per cycle for zero-latency memory).
REQ-021 On accept with cache_done=1: the word is captured in a hold buffer, outputs unchanged, next state HOLD.
REQ-022 In HOLD, the first cycle with cache_done=0 SHALL transfer the buffer to the outputs per REQ-020 and return to FETCH.
REQ-023 While cache_done=0 and no instruction is accepted, if_valid SHALL be 0 next cycle (bubble).
REQ-024 branch_taken SHALL be sampled only when cache_done=0; pc<={branch_target[31:2],2'b00}; if_valid<=0 next cycle.
REQ-025 Redirect in WAIT with inst_ready=0 SHALL go to DROP; DROP discards the next inst_ready and then enters FETCH at the new pc.
REQ-026 Redirect in HOLD, or coincident with an accept, SHALL discard that word; redirect wins over accept.
REQ-027 halted_wire=1 with cache_done=0 SHALL enter HALTED: if_valid<=0, halted_out<=1, no further requests until reset; halt wins over redirect.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).

Reset
REQ-029 rst_b=0 SHALL immediately force: pc=RESET_PC, state FETCH, inst_out=32'h0 (NOP), PC_plus_4=0, if_valid=0, halted_out=0, counters 0, hold buffer 0.
REQ-030 Reset mid-WAIT SHALL abandon the transaction; a late inst_ready after release SHALL be handled as normal FETCH acceptance only if inst_req=1.

Configuration
REQ-031 FETCH_STATS_EN defined: fetch_count increments per accepted instruction delivered (REQ-020/022); stall_count increments per cycle with inst_req=1 and inst_ready=0, or in HOLD; both saturate at 32'hFFFF_FFFF.
REQ-032 FETCH_STATS_EN undefined: counter ports and logic SHALL be absent.

Structure
REQ-033 Shared package mips_pkg SHALL hold fetch_state_t enum, NOP_INST constant and default RESET_PC constant.
REQ-034 No sub-module; hold buffer and FSM inside fetch_stage.

Verification
REQ-035 Zero-latency memory, cache_done=0: after reset, inst_out sequence at 0x0,0x4,0x8 on consecutive cycles, PC_plus_4=0x4,0x8,0xC.
REQ-036 inst_ready delayed 3 cycles: inst_req high 4 cycles, if_valid=0 for 3 cycles, then 1 with correct word.
REQ-037 cache_done=1 for 5 cycles during accept: outputs frozen, HOLD entered, word delivered the cycle cache_done falls, no word lost or duplicated.
REQ-038 branch_taken with target 0x103 while in WAIT: DROP, stale word discarded, next fetch address 0x100, one bubble minimum.
REQ-039 halted_wire pulse: halted_out=1 and inst_req=0 forever; reset restores fetch at RESET_PC.
REQ-040 pc=0xFFFF_FFFC fetch: next inst_addr=0x0; with FETCH_STATS_EN, fetch_count and stall_count match delivered/waited cycle counts.
